// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, S-box/pLayer helpers and FSM state type.
// Used by both the encrypt core and the key-schedule sub-module.
package present_pkg;

   localparam int SIZE       = 64;
   localparam int KEY_SIZE   = 80;
   localparam int NUM_ROUNDS = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FINAL = 2'd2
   } state_t;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [SIZE-1:0] sbox_layer(input logic [SIZE-1:0] x);
      logic [SIZE-1:0] y;
      y = '0;
      for (int n = 0; n < SIZE / 4; n++) begin
         y[4*n +: 4] = sbox(x[4*n +: 4]);
      end
      return y;
   endfunction

   // Bit i lands at (16*i) mod 63; bit 63 stays in place.
   function automatic logic [SIZE-1:0] p_layer(input logic [SIZE-1:0] x);
      logic [SIZE-1:0] y;
      logic [5:0]      src;
      logic [5:0]      dst;
      y     = '0;
      y[63] = x[63];
      for (int i = 0; i < SIZE - 1; i++) begin
         src    = 6'(i);
         dst    = 6'((16 * i) % 63);
         y[dst] = x[src];
      end
      return y;
   endfunction

endpackage

// File: rtl/present_key_update.sv
// Combinational PRESENT-80 next round key: rotate left 61, S-box top nibble,
// XOR the 5-bit round counter into bits [19:15].
module present_key_update
   import present_pkg::*;
(
   input  logic [KEY_SIZE-1:0] key,
   input  logic [4:0]          round,
   output logic [KEY_SIZE-1:0] next_key
);

   logic [KEY_SIZE-1:0] rot;

   always_comb begin
      rot              = {key[18:0], key[79:19]};
      next_key         = rot;
      next_key[79:76]  = sbox(rot[79:76]);
      next_key[19:15]  = rot[19:15] ^ round;
   end

endmodule

// File: rtl/present_encrypt.sv
// Iterative PRESENT-80 encryptor, one round per clock, round keys computed on the fly.
// Latency: Done pulses 32 clocks after the accepting Start edge; 33-cycle block period.
// Backpressure: none; Start is ignored while Busy. PRESENT_LAST_KEY_OUT_EN adds last_key.
module present_encrypt
   import present_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Start,
   input  logic [SIZE-1:0]     plaintext,
   input  logic [KEY_SIZE-1:0] orig_key,
   output logic [SIZE-1:0]     ciphertext,
   output logic                Busy,
   output logic                Done
`ifdef PRESENT_LAST_KEY_OUT_EN
   ,
   output logic [KEY_SIZE-1:0] last_key
`endif
);

   state_t              fsm;
   state_t              fsm_nxt;
   logic                load;
   logic                step;
   logic                finish;
   logic [SIZE-1:0]     state_q;
   logic [KEY_SIZE-1:0] key_q;
   logic [KEY_SIZE-1:0] key_nxt;
   logic [4:0]          round;

   present_key_update u_key_update (
      .key      (key_q),
      .round    (round),
      .next_key (key_nxt)
   );

   always_ff @(posedge Clock) begin
      if (Reset) fsm <= IDLE;
      else       fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt = fsm;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (fsm)
         IDLE: begin
            if (Start) begin
               load    = 1'b1;
               fsm_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (round == 5'(NUM_ROUNDS)) fsm_nxt = FINAL;
         end
         FINAL: begin
            finish  = 1'b1;
            fsm_nxt = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= '0;
         key_q      <= '0;
         round      <= '0;
         ciphertext <= '0;
         Done       <= 1'b0;
`ifdef PRESENT_LAST_KEY_OUT_EN
         last_key   <= '0;
`endif
      end else begin
         Done <= finish;
         if (load) begin
            state_q <= plaintext;
            key_q   <= orig_key;
            round   <= 5'd1;
         end
         if (step) begin
            state_q <= p_layer(sbox_layer(state_q ^ key_q[79:16]));
            key_q   <= key_nxt;
            // Hold at the last round rather than wrapping to 0.
            if (round != 5'(NUM_ROUNDS)) round <= round + 5'd1;
         end
         if (finish) begin
            ciphertext <= state_q ^ key_q[79:16];
`ifdef PRESENT_LAST_KEY_OUT_EN
            last_key   <= key_q;
`endif
         end
      end
   end

   // Done cycle has the FSM back in IDLE but still counts as busy.
   assign Busy = (fsm != IDLE) || Done;

endmodule

// File: tb/tb_present_encrypt.sv
// Scoreboard bench for present_encrypt: known-answer vectors, latency, back-to-back,
// ignored Start while busy, and mid-run reset abort.
module tb_present_encrypt;
   import present_pkg::*;

   logic                Clock = 1'b0;
   logic                Reset;
   logic                Start;
   logic [SIZE-1:0]     plaintext;
   logic [KEY_SIZE-1:0] orig_key;
   logic [SIZE-1:0]     ciphertext;
   logic                Busy;
   logic                Done;
`ifdef PRESENT_LAST_KEY_OUT_EN
   logic [KEY_SIZE-1:0] last_key;
`endif

   localparam logic [63:0] PT0 = 64'h0;
   localparam logic [63:0] PTF = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [79:0] K0  = 80'h0;
   localparam logic [79:0] KF  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

   always #5 Clock = ~Clock;

   present_encrypt dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Start      (Start),
      .plaintext  (plaintext),
      .orig_key   (orig_key),
      .ciphertext (ciphertext),
      .Busy       (Busy),
      .Done       (Done)
`ifdef PRESENT_LAST_KEY_OUT_EN
      ,
      .last_key   (last_key)
`endif
   );

   int n_tests   = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int prev_done = -1;
   int last_done = -1;
   logic [63:0] exp_q[$];
   int          acc_q[$];

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_sbox(input logic [3:0] x);
      logic [63:0] tbl;
      int          idx;
      tbl = 64'hC56B_90AD_3EF8_4712;
      idx = 63 - 4 * int'(x);
      return tbl[idx -: 4];
   endfunction

   function automatic logic [79:0] model_k32(input logic [79:0] k0);
      logic [79:0] k;
      k = k0;
      for (int r = 1; r <= 31; r++) begin
         k          = {k[18:0], k[79:19]};
         k[79:76]   = model_sbox(k[79:76]);
         k[19:15]   = k[19:15] ^ 5'(r);
      end
      return k;
   endfunction

   // Scoreboard: every Done pops one expected block and its accept cycle.
   always @(negedge Clock) begin
      if (Done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_done", 80'd1, 80'd0);
         end else begin
            check_eq("ciphertext", 80'(ciphertext), 80'(exp_q.pop_front()));
            check_eq("latency", 80'(cyc - acc_q.pop_front()), 80'd32);
            check_eq("busy_in_done", 80'(Busy), 80'd1);
         end
         prev_done = last_done;
         last_done = cyc;
      end
   end

   task automatic start_block(input logic [63:0] pt, input logic [79:0] k,
                              input logic [63:0] exp, input bit track);
      int guard;
      guard = 0;
      @(negedge Clock);
      while (Busy && !Done && guard < 100) begin
         @(negedge Clock);
         guard++;
      end
      if (guard >= 100) check_eq("start_timeout", 80'd1, 80'd0);
      Start     = 1'b1;
      plaintext = pt;
      orig_key  = k;
      @(posedge Clock);
      #1;
      if (track) begin
         exp_q.push_back(exp);
         acc_q.push_back(cyc);
      end
      Start     = 1'b0;
      plaintext = {$urandom, $urandom};
      orig_key  = {16'($urandom), $urandom, $urandom};
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 80) begin
         @(negedge Clock);
         guard++;
      end
      if (exp_q.size() != 0) begin
         check_eq("done_timeout", 80'd1, 80'd0);
         exp_q.delete();
         acc_q.delete();
      end
      @(negedge Clock);
   endtask

   initial begin
      Reset     = 1'b1;
      Start     = 1'b0;
      plaintext = '0;
      orig_key  = '0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check_eq("rst_busy", 80'(Busy), 80'd0);
      check_eq("rst_done", 80'(Done), 80'd0);
      check_eq("rst_ct", 80'(ciphertext), 80'd0);
      Reset = 1'b0;

      start_block(PT0, K0, 64'h5579C1387B228445, 1'b1);
      drain();
`ifdef PRESENT_LAST_KEY_OUT_EN
      check_eq("last_key", last_key, model_k32(K0));
      check_eq("last_key_xor", 80'(ciphertext ^ last_key[79:16]),
               80'(ciphertext ^ model_k32(K0)[79:16]));
`endif
      repeat (5) @(negedge Clock);
      check_eq("ct_hold", 80'(ciphertext), 80'(64'h5579C1387B228445));
      check_eq("done_low", 80'(Done), 80'd0);

      start_block(PT0, KF, 64'hE72C46C0F5945049, 1'b1);
      drain();
      start_block(PTF, K0, 64'hA112FFC72F68417B, 1'b1);
      drain();

      // Back-to-back with junk Start pulses while busy.
      start_block(PTF, KF, 64'h3333DCD3213210D2, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         check_eq("busy_run", 80'(Busy), 80'd1);
         Start     = 1'b1;
         plaintext = {$urandom, $urandom};
      end
      start_block(PT0, K0, 64'h5579C1387B228445, 1'b1);
      drain();
      check_eq("b2b_period", 80'(last_done - prev_done), 80'd33);

      // Abort mid-run: no Done may follow, outputs clear.
      start_block(PT0, KF, 64'hE72C46C0F5945049, 1'b0);
      repeat (10) @(posedge Clock);
      #1;
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(negedge Clock);
      check_eq("abort_busy", 80'(Busy), 80'd0);
      check_eq("abort_done", 80'(Done), 80'd0);
      check_eq("abort_ct", 80'(ciphertext), 80'd0);
      repeat (40) @(negedge Clock);
      start_block(PTF, K0, 64'hA112FFC72F68417B, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
